// File: rtl/keccak_rand_gen.sv
// ---- keccak_rand_gen: seeded parallel-LFSR randomness source for the masked chi layer ----
// ---- Rev 1.0 --------------------------------------------------------------------------------
`default_nettype none

module keccak_rand_gen #(
   parameter  int SHARES          = 6,
   parameter  int NUM_SBOX        = 1,
   parameter  int WARMUP_CYCLES   = 16,
   parameter  int RESEED_INTERVAL = 1024,
   localparam int ZW              = (SHARES*SHARES-SHARES)/2*5*NUM_SBOX,
   localparam int NUM_LFSR        = (ZW+31)/32
) (
   input  logic          ClkxCI,
   input  logic          RstxRBI,
   input  logic [31:0]   SeedxDI,
   input  logic          SeedValidxSI,
   output logic          SeedReadyxSO,
   output logic [ZW-1:0] ZxDO,
   output logic          ZValidxSO,
   input  logic          ZReadyxSI,
   output logic          ReseedReqxSO
);

   localparam int LCW = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1;
   localparam int WCW = $clog2(WARMUP_CYCLES+1);
   localparam int CCW = $clog2(RESEED_INTERVAL+1);

   typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, WARMUP = 2'd2, RUN = 2'd3} state_t;

   state_t          State_q;
   logic [31:0]     Lfsr_q [NUM_LFSR];
   logic [LCW-1:0]  LaneCnt_q;
   logic [WCW-1:0]  WarmCnt_q;
   logic [CCW-1:0]  ConsCnt_q;
   logic            ZValid_q, SeedReady_q, ReseedReq_q;
   logic [NUM_LFSR*32-1:0] LfsrFlat;
   logic            unused_lfsr_bits;
   logic            SeedHs, ZHs;

   // 32 unrolled Fibonacci steps: fb = s31^s21^s1^s0 shifted in at bit 0
   function automatic logic [31:0] advance(input logic [31:0] s);
      logic [31:0] t;
      t = s;
      for (int i = 0; i < 32; i++) t = {t[30:0], t[31] ^ t[21] ^ t[1] ^ t[0]};
      return t;
   endfunction

   function automatic logic [31:0] fix_seed(input logic [31:0] w);
      return (w == 32'h0) ? 32'h1 : w;
   endfunction

   assign SeedHs = SeedValidxSI & SeedReady_q;
   assign ZHs    = ZValid_q & ZReadyxSI;

   always_ff @(posedge ClkxCI or negedge RstxRBI) begin
      if (!RstxRBI) begin
         for (int k = 0; k < NUM_LFSR; k++) Lfsr_q[k] <= '0;
         State_q     <= IDLE;
         LaneCnt_q   <= '0;
         WarmCnt_q   <= '0;
         ConsCnt_q   <= '0;
         ZValid_q    <= 1'b0;
         SeedReady_q <= 1'b0;
         ReseedReq_q <= 1'b1;
      end else begin
         case (State_q)
            IDLE, RUN: begin
               SeedReady_q <= 1'b1;
               // A seed load outranks a simultaneous Z transfer for the state update
               if (SeedHs) begin
                  Lfsr_q[0]   <= fix_seed(SeedxDI);
                  ReseedReq_q <= 1'b0;
                  ConsCnt_q   <= '0;
                  ZValid_q    <= 1'b0;
                  LaneCnt_q   <= LCW'(1);
                  WarmCnt_q   <= '0;
                  if (NUM_LFSR == 1) begin
                     State_q     <= WARMUP;
                     SeedReady_q <= 1'b0;
                  end else begin
                     State_q <= SEED;
                  end
               end else if (State_q == RUN && ZHs) begin
                  for (int k = 0; k < NUM_LFSR; k++) Lfsr_q[k] <= advance(Lfsr_q[k]);
                  if (ConsCnt_q != CCW'(RESEED_INTERVAL)) ConsCnt_q <= ConsCnt_q + CCW'(1);
                  if (ConsCnt_q == CCW'(RESEED_INTERVAL-1)) ReseedReq_q <= 1'b1;
               end
            end
            SEED: begin
               if (SeedHs) begin
                  Lfsr_q[LaneCnt_q] <= fix_seed(SeedxDI);
                  if (LaneCnt_q == LCW'(NUM_LFSR-1)) begin
                     State_q     <= WARMUP;
                     WarmCnt_q   <= '0;
                     SeedReady_q <= 1'b0;
                  end else begin
                     LaneCnt_q <= LaneCnt_q + LCW'(1);
                  end
               end
            end
            WARMUP: begin
               for (int k = 0; k < NUM_LFSR; k++) Lfsr_q[k] <= advance(Lfsr_q[k]);
               WarmCnt_q <= WarmCnt_q + WCW'(1);
               if (WarmCnt_q == WCW'(WARMUP_CYCLES-1)) begin
                  State_q     <= RUN;
                  ZValid_q    <= 1'b1;
                  SeedReady_q <= 1'b1;
               end
            end
            default: State_q <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_LFSR; k++) begin : g_lane
      assign LfsrFlat[k*32 +: 32] = Lfsr_q[k];
   end

   // Lanes hold seeds and warm-up states outside RUN; mask them so no partial vector leaks
   assign ZxDO             = ZValid_q ? LfsrFlat[ZW-1:0] : '0;
   assign unused_lfsr_bits = ^LfsrFlat;
   assign ZValidxSO        = ZValid_q;
   assign SeedReadyxSO     = SeedReady_q;
   assign ReseedReqxSO     = ReseedReq_q;

endmodule

`default_nettype wire

// File: tb/tb_keccak_rand_gen.sv
// Testbench for keccak_rand_gen: random traffic against a bit-sequence LFSR model.
`timescale 1ns/1ps
`default_nettype none

module tb_keccak_rand_gen;

   localparam int SHARES = 6;
   localparam int NSBOX  = 1;
   localparam int WARM   = 16;
   localparam int RESEED = 4;
   localparam int ZW     = (SHARES*SHARES-SHARES)/2*5*NSBOX;
   localparam int NL     = (ZW+31)/32;

   logic          ClkxCI = 1'b0;
   logic          RstxRBI = 1'b0;
   logic [31:0]   SeedxDI = '0;
   logic          SeedValidxSI = 1'b0;
   logic          SeedReadyxSO;
   logic [ZW-1:0] ZxDO;
   logic          ZValidxSO;
   logic          ZReadyxSI = 1'b0;
   logic          ReseedReqxSO;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_lane [NL];
   int          m_cons;
   bit          m_req;

   keccak_rand_gen #(
      .SHARES(SHARES), .NUM_SBOX(NSBOX), .WARMUP_CYCLES(WARM), .RESEED_INTERVAL(RESEED)
   ) dut (
      .ClkxCI(ClkxCI), .RstxRBI(RstxRBI),
      .SeedxDI(SeedxDI), .SeedValidxSI(SeedValidxSI), .SeedReadyxSO(SeedReadyxSO),
      .ZxDO(ZxDO), .ZValidxSO(ZValidxSO), .ZReadyxSI(ZReadyxSI),
      .ReseedReqxSO(ReseedReqxSO)
   );

   always #5 ClkxCI = ~ClkxCI;

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: the lane is a bit stream u with u[t] = u[t-32]^u[t-22]^u[t-2]^u[t-1];
   // the state is the newest 32 bits, newest in bit 0.
   function automatic logic [31:0] ref_steps(input logic [31:0] s, input int n);
      bit u[$];
      logic [31:0] r;
      for (int b = 31; b >= 0; b--) u.push_back(s[b]);
      for (int t = 32; t < 32 + n; t++) u.push_back(u[t-32] ^ u[t-22] ^ u[t-2] ^ u[t-1]);
      for (int b = 0; b < 32; b++) r[b] = u[31 + n - b];
      return r;
   endfunction

   function automatic logic [ZW-1:0] ref_flat();
      logic [ZW-1:0] z;
      z = '0;
      for (int i = 0; i < ZW; i++) z[i] = m_lane[i/32][i%32];
      return z;
   endfunction

   task automatic seed_word(input logic [31:0] w);
      int n;
      n = 0;
      while (!SeedReadyxSO && n < 50) begin
         @(negedge ClkxCI);
         n++;
      end
      if (n >= 50) check_eq("seed_ready_timeout", 128'(SeedReadyxSO), 128'(1));
      SeedValidxSI = 1'b1;
      SeedxDI      = w;
      @(negedge ClkxCI);
      SeedValidxSI = 1'b0;
      SeedxDI      = $urandom;
   endtask

   task automatic load_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      logic [31:0] w [3];
      w[0] = w0; w[1] = w1; w[2] = w2;
      ZReadyxSI = 1'b0;
      for (int k = 0; k < NL; k++) begin
         if (k > 0) begin
            repeat ($urandom_range(0, 2)) begin
               SeedxDI = $urandom;
               @(negedge ClkxCI);
               check_eq("seed_gap_zvalid", 128'(ZValidxSO), 128'(0));
            end
         end
         seed_word(w[k]);
         m_lane[k] = (w[k] == 32'h0) ? 32'h1 : w[k];
      end
      m_cons = 0;
      m_req  = 1'b0;
   endtask

   task automatic warmup_check();
      int n;
      n = 0;
      check_eq("warm_seed_ready", 128'(SeedReadyxSO), 128'(0));
      while (!ZValidxSO && n < 100) begin
         @(negedge ClkxCI);
         n++;
      end
      check_eq("warmup_len", 128'(n), 128'(WARM));
      for (int k = 0; k < NL; k++) m_lane[k] = ref_steps(m_lane[k], 32*WARM);
      check_eq("first_word", 128'(ZxDO), 128'(ref_flat()));
      check_eq("first_reseed_req", 128'(ReseedReqxSO), 128'(0));
   endtask

   // rnd=0: ready always high; rnd=1: random ready
   task automatic run_cycles(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         check_eq("run_zvalid", 128'(ZValidxSO), 128'(1));
         check_eq("run_word", 128'(ZxDO), 128'(ref_flat()));
         check_eq("run_reseed_req", 128'(ReseedReqxSO), 128'(m_req));
         ZReadyxSI = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge ClkxCI);
         if (ZReadyxSI) begin
            for (int k = 0; k < NL; k++) m_lane[k] = ref_steps(m_lane[k], 32);
            m_cons++;
            if (m_cons >= RESEED) m_req = 1'b1;
         end
      end
      ZReadyxSI = 1'b0;
   endtask

   initial begin
      logic [ZW-1:0] hold;
      logic [31:0]   sw;

      repeat (2) @(negedge ClkxCI);
      check_eq("rst_z", 128'(ZxDO), 128'(0));
      check_eq("rst_zvalid", 128'(ZValidxSO), 128'(0));
      check_eq("rst_seed_ready", 128'(SeedReadyxSO), 128'(0));
      check_eq("rst_reseed_req", 128'(ReseedReqxSO), 128'(1));
      RstxRBI = 1'b1;
      @(negedge ClkxCI);

      // Known seeds, then stall and drain
      load_words(32'h1, 32'h2, 32'h3);
      warmup_check();
      hold = ZxDO;
      repeat (10) begin
         @(negedge ClkxCI);
         check_eq("stall_hold", 128'(ZxDO), 128'(hold));
      end
      run_cycles(5, 1'b0);
      run_cycles(30, 1'b1);

      // Seed and Z handshake in the same RUN cycle
      sw = $urandom;
      check_eq("simul_old_word", 128'(ZxDO), 128'(ref_flat()));
      ZReadyxSI    = 1'b1;
      SeedValidxSI = 1'b1;
      SeedxDI      = sw;
      @(negedge ClkxCI);
      ZReadyxSI    = 1'b0;
      SeedValidxSI = 1'b0;
      m_lane[0] = (sw == 32'h0) ? 32'h1 : sw;
      check_eq("simul_zvalid_drop", 128'(ZValidxSO), 128'(0));
      check_eq("simul_z_masked", 128'(ZxDO), 128'(0));
      check_eq("simul_reseed_clr", 128'(ReseedReqxSO), 128'(0));
      check_eq("simul_seed_ready", 128'(SeedReadyxSO), 128'(1));
      seed_word(32'hA5A5_0001);
      m_lane[1] = 32'hA5A5_0001;
      seed_word(32'h0);
      m_lane[2] = 32'h1;
      m_cons = 0;
      m_req  = 1'b0;
      warmup_check();
      run_cycles(8, 1'b1);

      // All-zero seeds become 1 in every lane
      load_words(32'h0, 32'h0, 32'h0);
      warmup_check();
      check_eq("zero_seed_lane01", 128'(ZxDO[63:32]), 128'(ZxDO[31:0]));
      check_eq("zero_seed_nonzero", 128'(ZxDO != '0), 128'(1));
      run_cycles(6, 1'b0);

      // Random seeds
      load_words($urandom, $urandom, $urandom);
      warmup_check();
      run_cycles(20, 1'b1);

      // Asynchronous reset in the middle of warm-up
      load_words($urandom, $urandom, $urandom);
      repeat (8) @(negedge ClkxCI);
      #2 RstxRBI = 1'b0;
      #1;
      check_eq("mid_rst_z", 128'(ZxDO), 128'(0));
      check_eq("mid_rst_zvalid", 128'(ZValidxSO), 128'(0));
      check_eq("mid_rst_seed_ready", 128'(SeedReadyxSO), 128'(0));
      check_eq("mid_rst_reseed_req", 128'(ReseedReqxSO), 128'(1));
      @(negedge ClkxCI);
      RstxRBI = 1'b1;
      repeat (25) begin
         @(negedge ClkxCI);
         check_eq("post_rst_no_valid", 128'(ZValidxSO), 128'(0));
      end
      load_words($urandom, $urandom, $urandom);
      warmup_check();
      run_cycles(10, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire
